sky_cycle_ctrl: RTL
===================

Name: sky_cycle_ctrl

Overview:
Day/night sequencer for the star-field renderer. It advances once per video frame and generates the `fade_level` and `frame_count` values that the star renderer consumes, plus a registered night flag and a per-star twinkle enable mask. It sits between display timing (the frame strobe source) and the sky/star renderers, all on the pixel clock.

Parameters:
- DAY_LEVEL, 136, fade value held during DAY; must lie in 64..208.
- FADE_STEP, 4, fade increment per frame during DUSK and DAWN; 1..64.
- HOLD_DAY, 600, frames spent in DAY before DUSK begins; ≥1.
- HOLD_NIGHT, 900, frames spent in NIGHT before DAWN begins; ≥1.
- TWK_LOG2, 4, twinkle mask refreshes every 2^TWK_LOG2 frames; 1..15.
- NSTARS, 12, width of the twinkle mask; 1..16.

Ports:
- clk_pix, in, 1, pixel clock; the only clock.
- rst_pix, in, 1, reset; synchronous, active-high.
- frame_start, in, 1, single-cycle pulse once per frame.
- pause, in, 1, freezes the FSM, fade, hold counter and LFSR; frame_count keeps counting.
- force_night, in, 1, level; sampled only on frame_start.
- fade_level, out, 8, registered fade value.
- frame_count, out, 16, registered count of frame_start pulses.
- is_night, out, 1, registered; equals (fade_level<64)||(fade_level>208).
- phase, out, 2, current state: DAY=0, DUSK=1, NIGHT=2, DAWN=3.
- star_en, out, NSTARS, twinkle mask; bit i enables star i.

Behaviour:
- Everything is synchronous to clk_pix. rst_pix has priority over all other inputs and takes effect on the next edge, including mid-fade.
- Reset values:
  - phase=DAY, fade_level=DAY_LEVEL, frame_count=0, is_night=0, star_en=0.
  - Hold counter=0, 16-bit LFSR=16'hACE1.
- State changes only on a clk_pix edge where frame_start=1. Outputs are valid on the following cycle, so latency is 1 clock. With frame_start=0, all registers hold.
- frame_count increments by 1 on every frame_start, wraps 16'hFFFF→0, and ignores pause.
- When pause=1 and frame_start=1: only frame_count updates. force_night is ignored.
- FSM, evaluated on each frame_start with pause=0:
  - DAY: hold_cnt++. When hold_cnt reaches HOLD_DAY-1: hold_cnt←0, go to DUSK. fade stays at DAY_LEVEL.
  - DUSK: fade←min(fade+FADE_STEP, 255), computed at 9 bits and then saturated. The frame in which fade becomes 255 also sets phase←NIGHT and hold_cnt←0.
  - NIGHT: fade=255. hold_cnt++. When hold_cnt reaches HOLD_NIGHT-1: hold_cnt←0, fade←0, go to DAWN.
  - DAWN: fade←min(fade+FADE_STEP, DAY_LEVEL). The frame in which fade reaches DAY_LEVEL also sets phase←DAY and hold_cnt←0.
- force_night=1 on a frame_start with pause=0 overrides the FSM:
  - phase←NIGHT, fade←255, hold_cnt←0.
  - If already in NIGHT, this restarts the hold.
- is_night is updated in the same cycle as fade_level, from the next-state fade value. It is never stale relative to fade_level.
- Twinkle LFSR: Galois form, polynomial x^16+x^14+x^13+x^11+1 (taps 16'hB400). It steps on a frame_start with pause=0 when frame_count[TWK_LOG2-1:0]==all-ones, where frame_count is the pre-increment value.
- star_en:
  - When the next is_night=1: star_en←LFSR_next[NSTARS-1:0].
  - If that value is all-zero, star_en←1 (at least one star is always lit).
  - When the next is_night=0: star_en←0.
  - star_en is updated on every frame_start, so it clears immediately at the night→day boundary even when the LFSR does not step.
- The hold counter is 16 bits. HOLD values above 65536 are unsupported.

Test Plan:
1. Reset with frame_start idle, then release → fade_level=136, phase=0, frame_count=0, star_en=0, is_night=0 held indefinitely.
2. HOLD_DAY=2, FADE_STEP=64, pulse frame_start every 10 clocks:
   - fade sequence per frame: 136,136,200,255(sat).
   - phase goes 0→1→2, reaching 2 on the frame fade hits 255.
   - is_night=1 from fade=255; star_en≠0 one clock after that frame_start.
3. HOLD_NIGHT=2 from NIGHT:
   - After 2 frames: fade=0, phase=3, is_night=1.
   - Then fade 64,128,136, with is_night=0 at 64 and star_en=0 in the same cycle.
   - phase=0 at 136.
4. pause=1 for 5 frame_starts in DUSK at fade=72 → fade stays 72, phase stays 1, frame_count advances by 5; force_night=1 is ignored while paused.
5. force_night=1 on a DAY frame_start with pause=0 → next cycle fade=255, phase=2, hold restarts (NIGHT lasts HOLD_NIGHT frames); asserting rst_pix mid-DAWN → next cycle reset values.
6. Preload frame_count=16'hFFFF via 65535 pulses (or a backdoor force) → next pulse gives 0; the LFSR steps exactly once per 16 frames (TWK_LOG2=4), and star_en is never 0 while is_night=1.

Source files
------------

// File: rtl/sky_cycle_ctrl.sv
// Day/night sequencer for the star-field renderer.
// Advances once per frame_start: fade ramp, hold timers, night flag and twinkle mask.
module sky_cycle_ctrl #(
    parameter int unsigned DAY_LEVEL  = 136,
    parameter int unsigned FADE_STEP  = 4,
    parameter int unsigned HOLD_DAY   = 600,
    parameter int unsigned HOLD_NIGHT = 900,
    parameter int unsigned TWK_LOG2   = 4,
    parameter int unsigned NSTARS     = 12
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              frame_start,
    input  logic              pause,
    input  logic              force_night,
    output logic [7:0]        fade_level,
    output logic [15:0]       frame_count,
    output logic              is_night,
    output logic [1:0]        phase,
    output logic [NSTARS-1:0] star_en
);

    typedef enum logic [1:0] {
        StDay   = 2'd0,
        StDusk  = 2'd1,
        StNight = 2'd2,
        StDawn  = 2'd3
    } phase_e;

    localparam logic [15:0] HoldDayLast   = 16'(HOLD_DAY - 1);
    localparam logic [15:0] HoldNightLast = 16'(HOLD_NIGHT - 1);
    localparam logic [7:0]  DayLevel      = 8'(DAY_LEVEL);
    localparam logic [8:0]  FadeStep      = 9'(FADE_STEP);
    localparam logic [15:0] LfsrSeed      = 16'hACE1;
    localparam logic [15:0] LfsrTaps      = 16'hB400;

    phase_e             phase_q, phase_d;
    logic [7:0]         fade_q, fade_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [15:0]        hold_q, hold_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               is_night_q, is_night_d;
    logic [NSTARS-1:0]  star_en_q, star_en_d;
    logic [8:0]         fade_sum;
    logic [NSTARS-1:0]  star_pick;

    // Next-state: frame counter always advances; the rest only when not paused.
    always_comb begin
        phase_d     = phase_q;
        fade_d      = fade_q;
        frame_cnt_d = frame_cnt_q;
        hold_d      = hold_q;
        lfsr_d      = lfsr_q;
        is_night_d  = is_night_q;
        star_en_d   = star_en_q;
        fade_sum    = {1'b0, fade_q} + FadeStep;
        star_pick   = '0;

        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (!pause) begin
                // Twinkle refresh uses the pre-increment frame count.
                if (frame_cnt_q[TWK_LOG2-1:0] == '1) begin
                    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
                end

                if (force_night) begin
                    phase_d = StNight;
                    fade_d  = 8'd255;
                    hold_d  = 16'd0;
                end else begin
                    unique case (phase_q)
                        StDay: begin
                            fade_d = DayLevel;
                            if (hold_q == HoldDayLast) begin
                                hold_d  = 16'd0;
                                phase_d = StDusk;
                            end else begin
                                hold_d = hold_q + 16'd1;
                            end
                        end
                        StDusk: begin
                            if (fade_sum >= 9'd255) begin
                                fade_d  = 8'd255;
                                phase_d = StNight;
                                hold_d  = 16'd0;
                            end else begin
                                fade_d = fade_sum[7:0];
                            end
                        end
                        StNight: begin
                            fade_d = 8'd255;
                            if (hold_q == HoldNightLast) begin
                                hold_d  = 16'd0;
                                fade_d  = 8'd0;
                                phase_d = StDawn;
                            end else begin
                                hold_d = hold_q + 16'd1;
                            end
                        end
                        StDawn: begin
                            if (fade_sum >= {1'b0, DayLevel}) begin
                                fade_d  = DayLevel;
                                phase_d = StDay;
                                hold_d  = 16'd0;
                            end else begin
                                fade_d = fade_sum[7:0];
                            end
                        end
                    endcase
                end

                // Night flag and mask follow the new fade so they never lag it.
                is_night_d = (fade_d < 8'd64) || (fade_d > 8'd208);
                star_pick  = lfsr_d[NSTARS-1:0];
                if (!is_night_d) begin
                    star_en_d = '0;
                end else if (star_pick == '0) begin
                    star_en_d = NSTARS'(1);
                end else begin
                    star_en_d = star_pick;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            phase_q     <= StDay;
            fade_q      <= DayLevel;
            frame_cnt_q <= 16'd0;
            hold_q      <= 16'd0;
            lfsr_q      <= LfsrSeed;
            is_night_q  <= 1'b0;
            star_en_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            fade_q      <= fade_d;
            frame_cnt_q <= frame_cnt_d;
            hold_q      <= hold_d;
            lfsr_q      <= lfsr_d;
            is_night_q  <= is_night_d;
            star_en_q   <= star_en_d;
        end
    end

    assign fade_level  = fade_q;
    assign frame_count = frame_cnt_q;
    assign is_night    = is_night_q;
    assign phase       = phase_q;
    assign star_en     = star_en_q;

endmodule
